// File: rtl/inst_buf_pkg.sv
// Shared definitions for the fetch/decode boundary: default widths and the
// well-known program counter constants used by fetch and the instruction buffer.
package inst_buf_pkg;

  localparam int INST_L_DEF = 32;
  localparam int PC_L_DEF   = 32;

  // Reset vector and start of the main program image
  localparam logic [31:0] PC_ENTRY = 32'h0000_0000;
  localparam logic [31:0] PC_MAIN  = 32'h0000_1000;

endpackage

// File: rtl/inst_buf_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; only the pointers in the parent define which entries are live.
module inst_buf_ram #(
  parameter int DEPTH = 4,
  parameter int PTR_L = 2,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_L-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_L-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Store the incoming entry at the write address
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_buf.sv
// Instruction queue between fetch and decode with a show-ahead read port.
// Optional macro INST_BUF_BYPASS_EN: when the queue is empty and fetch writes,
// the incoming pc/inst is presented on the outputs in the same cycle and may be
// consumed by decode without ever being stored.
module inst_buf
  import inst_buf_pkg::*;
#(
  parameter int INST_L = INST_L_DEF,
  parameter int PC_L   = PC_L_DEF,
  parameter int DEPTH  = 4,
  parameter int PTR_L  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PC_L-1:0]   pc_in,
  input  logic [INST_L-1:0] inst_in,
  output logic              buf_avail,
  output logic              buf_ack,
  input  logic              purge,
  input  logic              re,
  output logic              valid,
  output logic [PC_L-1:0]   pc_out,
  output logic [INST_L-1:0] inst_out,
  output logic [PTR_L:0]    count,
  output logic              ovf
);

  localparam int             ENT_L    = PC_L + INST_L;
  localparam logic [PTR_L:0] FULL_CNT = (PTR_L + 1)'(DEPTH);

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]   count_q, count_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;

  logic             empty, full;
  logic             pop, accept, store, byp;
  logic [ENT_L-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef INST_BUF_BYPASS_EN
  assign byp = empty && we && !purge;
`else
  assign byp = 1'b0;
`endif

  // A stored entry leaves only when one exists; purge cancels every request.
  assign pop    = re && !empty && !purge;
  assign accept = we && !purge && (!full || pop);
  // A bypassed entry that decode takes immediately never occupies a slot.
  assign store  = accept && !(byp && re);

  inst_buf_ram #(
    .DEPTH (DEPTH),
    .PTR_L (PTR_L),
    .W     (ENT_L)
  ) u_ram (
    .clk     (clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i ({pc_in, inst_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Next-state for pointers, occupancy, write acknowledge and overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    ovf_d    = ovf_q;
    if (purge) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + PTR_L'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_L'(1);
      end
      count_d = count_q + {{PTR_L{1'b0}}, store} - {{PTR_L{1'b0}}, pop};
      ack_d   = accept;
      if (we && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  // Show-ahead head selection; outputs read as zero when nothing is presented
  always_comb begin
    valid    = !empty || byp;
    pc_out   = '0;
    inst_out = '0;
    if (!empty) begin
      pc_out   = head[ENT_L-1:INST_L];
      inst_out = head[INST_L-1:0];
    end else if (byp) begin
      pc_out   = pc_in;
      inst_out = inst_in;
    end
  end

  assign buf_avail = !full;
  assign buf_ack   = ack_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule
